muldiv_ctrl: RTL and testbench

- Sequencer for the EX-stage multiply/divide resources.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and registers the operands.
- Drives the pipelined multiplier (fixed latency) and the iterative divider (start/ready handshake).
- Stalls the pipeline while an operation is in flight, honours flushE, and issues exactly one HI/LO write per committed operation.

---
 rtl/muldiv_ctrl_pkg.sv | 25 ++
 rtl/muldiv_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer and the decoder
// that feeds it: request op codes, FSM states and the divide-by-zero result.
package muldiv_ctrl_pkg;

    localparam logic [2:0] MULDIV_OP_MULT  = 3'd0;
    localparam logic [2:0] MULDIV_OP_MULTU = 3'd1;
    localparam logic [2:0] MULDIV_OP_DIV   = 3'd2;
    localparam logic [2:0] MULDIV_OP_DIVU  = 3'd3;
    localparam logic [2:0] MULDIV_OP_MTHI  = 3'd4;
    localparam logic [2:0] MULDIV_OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    // Divide by zero never reaches the divider: HI keeps the dividend and
    // LO reads all ones, matching what the iterative divider would produce.
    function automatic logic [63:0] div_zero_result(input logic [31:0] dividend);
        return {dividend, 32'hFFFF_FFFF};
    endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// EX-stage multiply/divide sequencer. Registers operands for the external
// pipelined multiplier and iterative divider, stalls IF..EX while an
// operation is in flight, and emits exactly one HI/LO write per committed op.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flushE,
    input  logic [63:0] hilo_q,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic        op_signed,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_cancel,
    input  logic [63:0] div_result,
    input  logic        div_ready,
    output logic        stall,
    output logic        busy,
    output logic        hilo_we,
    output logic [63:0] hilo_wdata
);

    // Wide enough to hold MUL_LAT itself so the terminal compare is exact.
    localparam int CNT_W = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    md_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]     op_a_q, op_a_d;
    logic [31:0]     op_b_q, op_b_d;
    logic            op_signed_q, op_signed_d;
    logic            div_start_q, div_start_d;
    logic            div_cancel_q, div_cancel_d;
    logic [63:0]     result_q, result_d;

    logic            stall_c;
    logic            hilo_we_c;
    logic [63:0]     hilo_wdata_c;

    // Next-state, operand capture and the combinational stall/write strobes.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_signed_d  = op_signed_q;
        div_start_d  = 1'b0;
        div_cancel_d = 1'b0;
        result_d     = result_q;
        stall_c      = 1'b0;
        hilo_we_c    = 1'b0;
        hilo_wdata_c = 64'd0;

        case (state_q)
            MD_IDLE: begin
                if (req_valid && !flushE) begin
                    case (req_op)
                        MULDIV_OP_MTHI: begin
                            hilo_we_c    = 1'b1;
                            hilo_wdata_c = {src_a, hilo_q[31:0]};
                        end
                        MULDIV_OP_MTLO: begin
                            hilo_we_c    = 1'b1;
                            hilo_wdata_c = {hilo_q[63:32], src_a};
                        end
                        MULDIV_OP_MULT, MULDIV_OP_MULTU: begin
                            op_a_d      = src_a;
                            op_b_d      = src_b;
                            op_signed_d = (req_op == MULDIV_OP_MULT);
                            cnt_d       = CNT_ONE;
                            state_d     = MD_MUL;
                            stall_c     = 1'b1;
                        end
                        MULDIV_OP_DIV, MULDIV_OP_DIVU: begin
                            stall_c = 1'b1;
                            if (src_b != 32'd0) begin
                                op_a_d      = src_a;
                                op_b_d      = src_b;
                                op_signed_d = (req_op == MULDIV_OP_DIV);
                                div_start_d = 1'b1;
                                state_d     = MD_DIV;
                            end else begin
                                result_d = div_zero_result(src_a);
                                state_d  = MD_DONE;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end

            MD_MUL: begin
                if (flushE) begin
                    cnt_d   = '0;
                    state_d = MD_IDLE;
                end else begin
                    stall_c = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        result_d = mul_result;
                        cnt_d    = '0;
                        state_d  = MD_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            MD_DIV: begin
                // A flush beats a same-cycle div_ready: the result is dropped.
                if (flushE) begin
                    div_cancel_d = 1'b1;
                    state_d      = MD_IDLE;
                end else begin
                    stall_c = 1'b1;
                    if (div_ready) begin
                        result_d = div_result;
                        state_d  = MD_DONE;
                    end
                end
            end

            MD_DONE: begin
                // EX advances this cycle; the new instruction is seen next cycle.
                state_d = MD_IDLE;
                if (!flushE) begin
                    hilo_we_c    = 1'b1;
                    hilo_wdata_c = result_q;
                end
            end

            default: begin
                state_d = MD_IDLE;
            end
        endcase
    end

    // FSM state, latency counter and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= MD_IDLE;
            cnt_q        <= '0;
            op_a_q       <= 32'd0;
            op_b_q       <= 32'd0;
            op_signed_q  <= 1'b0;
            div_start_q  <= 1'b0;
            div_cancel_q <= 1'b0;
            result_q     <= 64'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_signed_q  <= op_signed_d;
            div_start_q  <= div_start_d;
            div_cancel_q <= div_cancel_d;
            result_q     <= result_d;
        end
    end

    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign op_signed  = op_signed_q;
    assign div_start  = div_start_q;
    assign div_cancel = div_cancel_q;
    assign stall      = stall_c;
    assign busy       = (state_q != MD_IDLE);
    assign hilo_we    = hilo_we_c;
    assign hilo_wdata = hilo_wdata_c;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a one-register multiplier model
// (MUL_LAT=2) and a hand-driven divider handshake.
module tb_muldiv_ctrl;

    localparam int MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flushE;
    logic [63:0] hilo_q;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_signed;
    logic [63:0] mul_result;
    logic        div_start;
    logic        div_cancel;
    logic [63:0] div_result;
    logic        div_ready;
    logic        stall;
    logic        busy;
    logic        hilo_we;
    logic [63:0] hilo_wdata;

    int total = 0;
    int bad   = 0;

    muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .src_a      (src_a),
        .src_b      (src_b),
        .flushE     (flushE),
        .hilo_q     (hilo_q),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_signed  (op_signed),
        .mul_result (mul_result),
        .div_start  (div_start),
        .div_cancel (div_cancel),
        .div_result (div_result),
        .div_ready  (div_ready),
        .stall      (stall),
        .busy       (busy),
        .hilo_we    (hilo_we),
        .hilo_wdata (hilo_wdata)
    );

    always #5 clk = ~clk;

    // Multiplier model: MUL_LAT-1 register stages after the operand register.
    logic [63:0] mul_pipe;
    always_ff @(posedge clk) begin
        if (op_signed)
            mul_pipe <= 64'($signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b}));
        else
            mul_pipe <= {32'd0, op_a} * {32'd0, op_b};
    end
    assign mul_result = mul_pipe;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_op     = 3'd0;
        src_a      = 32'd0;
        src_b      = 32'd0;
        flushE     = 1'b0;
        hilo_q     = 64'd0;
        div_result = 64'd0;
        div_ready  = 1'b0;

        // Reset state
        #2;
        chk("rst_op_a", 64'(op_a), 64'd0);
        chk("rst_op_b", 64'(op_b), 64'd0);
        chk("rst_signed", 64'(op_signed), 64'd0);
        chk("rst_start", 64'(div_start), 64'd0);
        chk("rst_cancel", 64'(div_cancel), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        next();
        next();
        rst = 1'b1;
        next();

        // MULT -2 * 3: stall for accept + two MUL cycles, then DONE
        req_valid = 1'b1; req_op = 3'd0; src_a = 32'hFFFF_FFFE; src_b = 32'd3;
        settle();
        chk("mul_t0_stall", 64'(stall), 64'd1);
        chk("mul_t0_we", 64'(hilo_we), 64'd0);
        next(); settle();
        chk("mul_t1_stall", 64'(stall), 64'd1);
        chk("mul_t1_busy", 64'(busy), 64'd1);
        chk("mul_t1_op_a", 64'(op_a), 64'h0000_0000_FFFF_FFFE);
        chk("mul_t1_signed", 64'(op_signed), 64'd1);
        next(); settle();
        chk("mul_t2_stall", 64'(stall), 64'd1);
        chk("mul_t2_we", 64'(hilo_we), 64'd0);
        next(); settle();
        chk("mul_done_stall", 64'(stall), 64'd0);
        chk("mul_done_we", 64'(hilo_we), 64'd1);
        chk("mul_done_wdata", hilo_wdata, 64'hFFFF_FFFF_FFFF_FFFA);

        // Back-to-back DIV 5/0 right after DONE: accepted, no divider start
        next();
        req_op = 3'd2; src_a = 32'd5; src_b = 32'd0;
        settle();
        chk("dz_idle_busy", 64'(busy), 64'd0);
        chk("dz_t0_stall", 64'(stall), 64'd1);
        chk("dz_t0_we", 64'(hilo_we), 64'd0);
        next(); settle();
        chk("dz_no_start", 64'(div_start), 64'd0);
        chk("dz_done_stall", 64'(stall), 64'd0);
        chk("dz_done_we", 64'(hilo_we), 64'd1);
        chk("dz_done_wdata", hilo_wdata, 64'h0000_0005_FFFF_FFFF);
        next();
        req_valid = 1'b0;
        settle();
        chk("dz_after_busy", 64'(busy), 64'd0);
        chk("dz_after_we", 64'(hilo_we), 64'd0);
        chk("dz_after_wdata", hilo_wdata, 64'd0);

        // Stray div_ready in IDLE is ignored
        div_ready = 1'b1; div_result = 64'h1111_2222_3333_4444;
        settle();
        chk("stray_rdy_we", 64'(hilo_we), 64'd0);
        next();
        div_ready = 1'b0;
        settle();
        chk("stray_rdy_busy", 64'(busy), 64'd0);
        chk("stray_rdy_we2", 64'(hilo_we), 64'd0);

        // DIVU 100/7 with ready 33 cycles after the start pulse
        req_valid = 1'b1; req_op = 3'd3; src_a = 32'd100; src_b = 32'd7;
        settle();
        chk("divu_t0_stall", 64'(stall), 64'd1);
        chk("divu_t0_start", 64'(div_start), 64'd0);
        next(); settle();
        chk("divu_start", 64'(div_start), 64'd1);
        chk("divu_signed", 64'(op_signed), 64'd0);
        chk("divu_op_b", 64'(op_b), 64'd7);
        chk("divu_t1_stall", 64'(stall), 64'd1);
        for (int i = 2; i < 34; i++) begin
            next(); settle();
            chk("divu_wait_start", 64'(div_start), 64'd0);
            chk("divu_wait_stall", 64'(stall), 64'd1);
        end
        next();
        div_ready = 1'b1; div_result = {32'd2, 32'd14};
        settle();
        chk("divu_rdy_stall", 64'(stall), 64'd1);
        chk("divu_rdy_we", 64'(hilo_we), 64'd0);
        next();
        div_ready = 1'b0; div_result = 64'd0;
        settle();
        chk("divu_done_stall", 64'(stall), 64'd0);
        chk("divu_done_we", 64'(hilo_we), 64'd1);
        chk("divu_done_wdata", hilo_wdata, {32'd2, 32'd14});
        next();
        req_valid = 1'b0;
        settle();
        chk("divu_after_busy", 64'(busy), 64'd0);

        // MTLO and MTHI write the same cycle without stalling
        hilo_q = 64'hAAAA_AAAA_BBBB_BBBB;
        req_valid = 1'b1; req_op = 3'd5; src_a = 32'h0000_1234;
        settle();
        chk("mtlo_we", 64'(hilo_we), 64'd1);
        chk("mtlo_wdata", hilo_wdata, 64'hAAAA_AAAA_0000_1234);
        chk("mtlo_stall", 64'(stall), 64'd0);
        next();
        req_op = 3'd4; src_a = 32'hCAFE_0001;
        settle();
        chk("mthi_busy", 64'(busy), 64'd0);
        chk("mthi_wdata", hilo_wdata, 64'hCAFE_0001_BBBB_BBBB);
        next();
        req_op = 3'd6;
        settle();
        chk("op6_we", 64'(hilo_we), 64'd0);
        chk("op6_stall", 64'(stall), 64'd0);

        // Flush in IDLE blocks acceptance
        req_op = 3'd0; flushE = 1'b1;
        settle();
        chk("flush_idle_stall", 64'(stall), 64'd0);
        next();
        flushE = 1'b0; req_valid = 1'b0;
        settle();
        chk("flush_idle_busy", 64'(busy), 64'd0);

        // DIV in flight, flush together with div_ready
        req_valid = 1'b1; req_op = 3'd2; src_a = 32'd20; src_b = 32'd3;
        next(); settle();
        chk("dflush_start", 64'(div_start), 64'd1);
        chk("dflush_signed", 64'(op_signed), 64'd1);
        next();
        div_ready = 1'b1; div_result = {32'd2, 32'd6}; flushE = 1'b1;
        settle();
        chk("dflush_stall", 64'(stall), 64'd0);
        chk("dflush_we", 64'(hilo_we), 64'd0);
        next();
        div_ready = 1'b0; flushE = 1'b0; req_valid = 1'b0;
        settle();
        chk("dflush_cancel", 64'(div_cancel), 64'd1);
        chk("dflush_busy", 64'(busy), 64'd0);
        chk("dflush_we2", 64'(hilo_we), 64'd0);
        next(); settle();
        chk("dflush_cancel_off", 64'(div_cancel), 64'd0);

        // Flush in MUL returns to IDLE without a write
        req_valid = 1'b1; req_op = 3'd1; src_a = 32'd9; src_b = 32'd9;
        next();
        flushE = 1'b1;
        settle();
        chk("mflush_stall", 64'(stall), 64'd0);
        next();
        flushE = 1'b0; req_valid = 1'b0;
        settle();
        chk("mflush_busy", 64'(busy), 64'd0);
        chk("mflush_we", 64'(hilo_we), 64'd0);
        next(); settle();
        chk("mflush_no_cancel", 64'(div_cancel), 64'd0);

        // Flush in DONE suppresses the write
        req_valid = 1'b1; req_op = 3'd1; src_a = 32'd4; src_b = 32'd5;
        next(); next(); next();
        flushE = 1'b1;
        settle();
        chk("doneflush_busy", 64'(busy), 64'd1);
        chk("doneflush_we", 64'(hilo_we), 64'd0);
        chk("doneflush_wdata", hilo_wdata, 64'd0);
        next();
        flushE = 1'b0; req_valid = 1'b0;
        settle();
        chk("doneflush_idle", 64'(busy), 64'd0);

        // Reset during MUL clears everything at once
        req_valid = 1'b1; req_op = 3'd0; src_a = 32'h0000_FFFF; src_b = 32'h0000_FFFF;
        next();
        req_valid = 1'b0; rst = 1'b0;
        settle();
        chk("mrst_op_a", 64'(op_a), 64'd0);
        chk("mrst_op_b", 64'(op_b), 64'd0);
        chk("mrst_signed", 64'(op_signed), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_stall", 64'(stall), 64'd0);
        chk("mrst_we", 64'(hilo_we), 64'd0);
        chk("mrst_cancel", 64'(div_cancel), 64'd0);
        next();
        rst = 1'b1;
        req_valid = 1'b1; req_op = 3'd1; src_a = 32'd2; src_b = 32'd3;
        settle();
        chk("mrst_multu_stall", 64'(stall), 64'd1);
        next(); next(); next();
        settle();
        chk("mrst_multu_we", 64'(hilo_we), 64'd1);
        chk("mrst_multu_wdata", hilo_wdata, 64'd6);
        next();
        req_valid = 1'b0;
        settle();
        chk("mrst_multu_idle", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
